// File: rtl/saladin_sched_pkg.sv
// ----------------------------------------------------------------------------
// saladin_sched_pkg
// Shared definitions for the round-robin multi-port bank scheduler:
//   - width helpers (request word, PLM input word, kernel count)
//   - request field offsets
//   - bank selection and bank-local address helpers
// Addresses are passed zero-extended to 32 bits so the helpers can serve any
// ADDR_WIDTH up to 32.
// ----------------------------------------------------------------------------
package saladin_sched_pkg;

  // Request word layout, LSB first: valid, write, value, addr.
  localparam int VALID_BIT = 0;
  localparam int WRITE_BIT = 1;
  localparam int VALUE_LSB = 2;

  function automatic int req_width(input int addr_width, input int value_width);
    return addr_width + value_width + 2;
  endfunction

  function automatic int plm_input_width(input int addr_width, input int value_width,
                                         input int nbanks);
    return addr_width - $clog2(nbanks) + value_width + 1;
  endfunction

  function automatic int nkernels(input int nbanks, input int nports);
    return nbanks * nports;
  endfunction

  // Interleaved mode spreads consecutive addresses across banks (low bits);
  // blocked mode gives each bank a contiguous region (high bits).
  function automatic int bank_of(input logic [31:0] addr, input int addr_width,
                                 input int nbanks, input int interleave);
    int lb;
    lb = $clog2(nbanks);
    if (interleave != 0) return int'(addr & 32'(nbanks - 1));
    return int'((addr >> (addr_width - lb)) & 32'(nbanks - 1));
  endfunction

  // Address inside the selected bank: the bank-select bits are removed.
  function automatic logic [31:0] local_addr(input logic [31:0] addr, input int addr_width,
                                             input int nbanks, input int interleave);
    int lb;
    lb = $clog2(nbanks);
    if (interleave != 0) return addr >> lb;
    return addr & ((32'd1 << (addr_width - lb)) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_port_picker.sv
// ----------------------------------------------------------------------------
// rr_port_picker
// One bank's round-robin selector. Scans the eligibility vector from the
// bank's pivot with wrap-around and picks up to NPORTS consumers, assigning
// them to ports 0, 1, ... in scan order. The pivot then moves to one past the
// last consumer picked, or stays put when nothing was picked.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   eligible_i    [NCONSUMERS]         consumers requesting this bank
//   sel_o         [NPORTS][NCONSUMERS] one-hot consumer select per port
//   sel_valid_o   [NPORTS]             port carries a selection
// ----------------------------------------------------------------------------
module rr_port_picker #(
  parameter int NCONSUMERS  = 16,
  parameter int NPORTS      = 2,
  parameter int PIVOT_RESET = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NCONSUMERS-1:0]                 eligible_i,
  output logic [NPORTS-1:0][NCONSUMERS-1:0]     sel_o,
  output logic [NPORTS-1:0]                     sel_valid_o
);

  localparam int PW = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [PW-1:0] pivot_q, pivot_d;

  // NOTE: every output of this block gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    int n;
    int idx;
    int last;
    sel_o       = '0;
    sel_valid_o = '0;
    pivot_d     = pivot_q;
    n           = 0;
    idx         = 0;
    last        = 0;
    for (int i = 0; i < NCONSUMERS; i++) begin
      idx = int'(pivot_q) + i;
      if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
      if (eligible_i[idx] && n < NPORTS) begin
        sel_o[n][idx]  = 1'b1;
        sel_valid_o[n] = 1'b1;
        last           = idx;
        n              = n + 1;
      end
    end
    if (n > 0) pivot_d = PW'((last + 1) % NCONSUMERS);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pivot_q <= PW'(PIVOT_RESET);
    else        pivot_q <= pivot_d;
  end

endmodule

// File: rtl/rr_multiport_bank_scheduler.sv
// ----------------------------------------------------------------------------
// rr_multiport_bank_scheduler
// Registered round-robin scheduler routing NCONSUMERS requests onto
// NBANKS x NPORTS PLM kernels, with a per-kernel read-return pipeline.
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   requests     [NCONSUMERS] {addr, value, write, valid}
//   grants       [NCONSUMERS] one-cycle pulse: request issued
//   plm_valid    [NKERNELS]   kernel carries a request this cycle
//   plm_inputs   [NKERNELS]   {local addr, value, write}
//   plm_rdata    [NKERNELS]   read data from each kernel
//   rdata        [NCONSUMERS] returned read data (held between pulses)
//   rdata_valid  [NCONSUMERS] one-cycle pulse: rdata valid
// ----------------------------------------------------------------------------
module rr_multiport_bank_scheduler
  import saladin_sched_pkg::*;
#(
  parameter int NCONSUMERS       = 16,
  parameter int NBANKS           = 4,
  parameter int NPORTS           = 2,
  parameter int ADDR_WIDTH       = 16,
  parameter int VALUE_WIDTH      = 8,
  parameter int INTERLEAVE       = 1,
  parameter int PLM_READ_LATENCY = 1
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic [NCONSUMERS-1:0][req_width(ADDR_WIDTH, VALUE_WIDTH)-1:0] requests,
  output logic [NCONSUMERS-1:0]                                       grants,
  output logic [nkernels(NBANKS, NPORTS)-1:0]                         plm_valid,
  output logic [nkernels(NBANKS, NPORTS)-1:0]
               [plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS)-1:0] plm_inputs,
  input  logic [nkernels(NBANKS, NPORTS)-1:0][VALUE_WIDTH-1:0]        plm_rdata,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]                      rdata,
  output logic [NCONSUMERS-1:0]                                       rdata_valid
);

  localparam int NK       = nkernels(NBANKS, NPORTS);
  localparam int PIW      = plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS);
  localparam int LAW      = ADDR_WIDTH - $clog2(NBANKS);
  localparam int ADDR_LSB = VALUE_LSB + VALUE_WIDTH;
  localparam int IDW      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int L        = PLM_READ_LATENCY;

  logic [NBANKS-1:0][NPORTS-1:0][NCONSUMERS-1:0] sel;
  logic [NBANKS-1:0][NPORTS-1:0]                 sel_valid;

  logic [NCONSUMERS-1:0]          grants_q, grants_d;
  logic [NK-1:0]                  plm_valid_q, plm_valid_d;
  logic [NK-1:0][PIW-1:0]         plm_inputs_q, plm_inputs_d;
  logic [NK-1:0][IDW-1:0]         issue_id_q, issue_id_d;
  logic [NK-1:0]                  issue_rd;
  logic [L-1:0][NK-1:0]           pipe_vld_q;
  logic [L-1:0][NK-1:0][IDW-1:0]  pipe_id_q;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] rdata_q, rdata_d;
  logic [NCONSUMERS-1:0]          rdata_valid_q, rdata_valid_d;

  // Per-bank eligibility and picker. A consumer granted last cycle is masked
  // so a request held across its grant is not issued twice.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [NCONSUMERS-1:0] elig;

    always_comb begin
      elig = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
        elig[c] = requests[c][VALID_BIT] && !grants_q[c] &&
                  (bank_of(32'(requests[c][ADDR_LSB +: ADDR_WIDTH]), ADDR_WIDTH,
                           NBANKS, INTERLEAVE) == b);
      end
    end

    rr_port_picker #(
      .NCONSUMERS  (NCONSUMERS),
      .NPORTS      (NPORTS),
      .PIVOT_RESET (b * NCONSUMERS / NBANKS)
    ) u_picker (
      .clk         (clk),
      .rst_n       (reset),
      .eligible_i  (elig),
      .sel_o       (sel[b]),
      .sel_valid_o (sel_valid[b])
    );
  end

  // Route each port's selected request onto its kernel.
  always_comb begin
    grants_d     = '0;
    plm_valid_d  = '0;
    plm_inputs_d = '0;
    issue_id_d   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      for (int p = 0; p < NPORTS; p++) begin
        plm_valid_d[b*NPORTS+p] = sel_valid[b][p];
        for (int c = 0; c < NCONSUMERS; c++) begin
          if (sel[b][p][c]) begin
            grants_d[c]              = 1'b1;
            issue_id_d[b*NPORTS+p]   = IDW'(c);
            plm_inputs_d[b*NPORTS+p] = {
              LAW'(local_addr(32'(requests[c][ADDR_LSB +: ADDR_WIDTH]), ADDR_WIDTH,
                              NBANKS, INTERLEAVE)),
              requests[c][VALUE_LSB +: VALUE_WIDTH],
              requests[c][WRITE_BIT]};
          end
        end
      end
    end
  end

  // Only reads enter the return pipeline.
  always_comb begin
    issue_rd = '0;
    for (int k = 0; k < NK; k++) issue_rd[k] = plm_valid_q[k] & ~plm_inputs_q[k][0];
  end

  // The last pipeline stage lines up with plm_rdata; at most one kernel
  // targets a given consumer per cycle.
  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = '0;
    for (int k = 0; k < NK; k++) begin
      if (pipe_vld_q[L-1][k]) begin
        rdata_d[pipe_id_q[L-1][k]]       = plm_rdata[k];
        rdata_valid_d[pipe_id_q[L-1][k]] = 1'b1;
      end
    end
  end

  // NOTE: the return pipeline is reset along with the rest so reads in flight
  // at reset are dropped rather than returned with stale ids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants_q      <= '0;
      plm_valid_q   <= '0;
      plm_inputs_q  <= '0;
      issue_id_q    <= '0;
      pipe_vld_q    <= '0;
      pipe_id_q     <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= '0;
    end else begin
      grants_q      <= grants_d;
      plm_valid_q   <= plm_valid_d;
      plm_inputs_q  <= plm_inputs_d;
      issue_id_q    <= issue_id_d;
      pipe_vld_q[0] <= issue_rd;
      pipe_id_q[0]  <= issue_id_q;
      for (int i = 1; i < L; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign grants      = grants_q;
  assign plm_valid   = plm_valid_q;
  assign plm_inputs  = plm_inputs_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
